// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch bus: instruction memory read port plus the decoder handshake.
// master = fetch unit side, slave = memory/decoder side.
interface instruction_fetch_unit_if #(
    parameter int AW = 8,
    parameter int IW = 14
);
    logic [AW-1:0] imem_addr;
    logic          imem_rd_en;
    logic [IW-1:0] imem_rdata;
    logic [5:0]    opcode;
    logic [IW-7:0] imm;
    logic          instr_valid;
    logic          pc_en;
    logic          stop_flag;
    logic          pc_load;
    logic [AW-1:0] pc_load_val;

    modport master (
        output imem_addr, imem_rd_en, opcode, imm, instr_valid,
        input  imem_rdata, pc_en, stop_flag, pc_load, pc_load_val
    );

    modport slave (
        input  imem_addr, imem_rd_en, opcode, imm, instr_valid,
        output imem_rdata, pc_en, stop_flag, pc_load, pc_load_val
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory, hands one opcode/imm per
// instruction to the decoder. Optional macro SINGLE_STEP_EN adds a `step` port and STEP_WAIT.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start after reset
// FETCH     | imem read issued at pc
// WAIT      | imem_rdata captured into opcode/imm
// EXEC      | instr_valid=1, decoder outputs pick the next pc
// HALT      | program stopped, done=1, start restarts from START_ADDR
// STEP_WAIT | (SINGLE_STEP_EN only) holds until step=1
module instruction_fetch_unit #(
    parameter int            AW         = 8,
    parameter int            IW         = 14,
    parameter logic [AW-1:0] START_ADDR = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
`ifdef SINGLE_STEP_EN
    input  logic                            step,
`endif
    instruction_fetch_unit_if.master        bus,
    output logic [AW-1:0]                   pc,
    output logic                            busy,
    output logic                            done
);

    localparam logic [5:0] NOOP = 6'b000001;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT      = 3'd2,
        EXEC      = 3'd3,
        HALT      = 3'd4
`ifdef SINGLE_STEP_EN
        ,STEP_WAIT = 3'd5
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [5:0]    opcode_q;
    logic [IW-7:0] imm_q;
    logic          exec_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    pc_d    = START_ADDR;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT:  state_d = EXEC;
            EXEC: begin
                // stop beats a jump, a jump beats a plain increment
                if (bus.stop_flag) begin
                    state_d = HALT;
                end else begin
                    if (bus.pc_load)
                        pc_d = bus.pc_load_val;
                    else if (bus.pc_en)
                        pc_d = pc_q + AW'(1);
`ifdef SINGLE_STEP_EN
                    state_d = STEP_WAIT;
`else
                    state_d = FETCH;
`endif
                end
            end
`ifdef SINGLE_STEP_EN
            STEP_WAIT: begin
                if (step)
                    state_d = FETCH;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // rdata is valid during WAIT, one cycle after the FETCH read strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q <= NOOP;
            imm_q    <= '0;
        end else if (state_q == WAIT) begin
            opcode_q <= bus.imem_rdata[IW-1:IW-6];
            imm_q    <= bus.imem_rdata[IW-7:0];
        end
    end

    assign exec_act        = (state_q == EXEC);
    assign bus.imem_addr   = pc_q;
    assign bus.imem_rd_en  = (state_q == FETCH);
    assign bus.instr_valid = exec_act;
    assign bus.opcode      = exec_act ? opcode_q : NOOP;
    assign bus.imm         = imm_q;
    assign pc              = pc_q;
    assign done            = (state_q == HALT);
`ifdef SINGLE_STEP_EN
    assign busy = (state_q == FETCH) || (state_q == WAIT) || (state_q == EXEC) ||
                  (state_q == STEP_WAIT);
`else
    assign busy = (state_q == FETCH) || (state_q == WAIT) || (state_q == EXEC);
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front end of the downsampling processor's control path. Owns the program counter and reads the instruction memory. Presents one opcode plus immediate per instruction to the instruction decoder. Consumes the decoder's pc_en, stop_flag and PC-write outputs to choose the next fetch address, and provides the start/done handshake to the host.

Parameters:
AW, 8, program counter / instruction memory address width
IW, 14, instruction word width; bits [IW-1:IW-6] are the opcode, bits [IW-7:0] are the immediate
START_ADDR, 0, PC value after reset and on every start

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  level; sampled in IDLE or HALT; begins program execution
imem_addr  out  AW  instruction memory read address
imem_rd_en  out  1  instruction memory read strobe
imem_rdata  in  IW  instruction word; valid one cycle after imem_rd_en
opcode  out  6  opcode to the decoder; forced to NOOP (6'b000001) whenever instr_valid=0
imm  out  IW-6  immediate field of the current instruction
instr_valid  out  1  high for exactly the EXEC cycle of each instruction
pc_en  in  1  from decoder; advance PC by 1
stop_flag  in  1  from decoder; halt after this instruction
pc_load  in  1  from decoder (c_bus_select[5], PC write)
pc_load_val  in  AW  jump target from the C bus
pc  out  AW  current PC
busy  out  1  high in FETCH, WAIT and EXEC
done  out  1  high in HALT

Behaviour:
- Reset (async, immediate, including mid-instruction): state=IDLE, pc=START_ADDR, opcode=NOOP, imm=0, instr_valid=0, imem_rd_en=0, imem_addr=START_ADDR, busy=0, done=0.
- States are IDLE, FETCH, WAIT, EXEC and HALT. All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- IDLE: when start=1, pc is set to START_ADDR and the state moves to FETCH.
- FETCH (1 cycle): imem_addr=pc, imem_rd_en=1. Then WAIT.
- WAIT (1 cycle): imem_rdata is captured into the opcode/imm registers. Then EXEC.
- EXEC (1 cycle): instr_valid=1 and the decoder outputs are sampled at the end of this cycle. The next PC is chosen by priority:
  1. stop_flag=1: pc holds and the state goes to HALT.
  2. Otherwise pc_load=1: pc is set to pc_load_val and the state goes to FETCH.
  3. Otherwise pc_en=1: pc is set to pc+1 and the state goes to FETCH.
  4. Otherwise pc holds and the state goes to FETCH, so the same address is re-fetched.
- Throughput: exactly 3 cycles per instruction. The first instr_valid appears 3 cycles after the cycle in which start is sampled high.
- PC wrap-around: pc+1 from 2^AW-1 gives 0, with no error indication.
- HALT: done=1, busy=0, opcode=NOOP. When start=1, pc is set to START_ADDR and the state goes to FETCH, clearing done on the next cycle.
- start is ignored in FETCH, WAIT and EXEC.
- The decoder inputs are ignored outside EXEC.
- An unknown opcode is passed through unchanged; the decoder's default behaviour advances the PC.

Optional Feature:
Macro SINGLE_STEP_EN.
- Defined: an extra input port `step` (1 bit) is present. After each EXEC that does not halt, the FSM enters the additional state STEP_WAIT. In STEP_WAIT, busy=1, instr_valid=0 and opcode=NOOP. The FSM moves to FETCH on the first cycle in which step=1. A step already high on entry to STEP_WAIT is honoured immediately.
- Not defined: the step port and the STEP_WAIT state do not exist, and the FSM runs freely from EXEC directly to FETCH.

Test Plan:
- Reset/idle: assert rst mid-WAIT -> same cycle: instr_valid=0, opcode=6'b000001, busy=0; after release pc=0 and state is IDLE.
- Sequential run: program {LDP1, LDP2, STOP} at 0..2, pulse start, with the decoder model connected -> instr_valid at cycles 3, 6 and 9 after start with opcodes 000010, 000011 and 011000; done=1 from cycle 10 with pc=2.
- Jump: at EXEC of address 5, drive pc_load=1, pc_load_val=8'h20, pc_en=1 -> the next imem_addr is 8'h20, not 6.
- Priority: at the same EXEC, drive stop_flag=1 and pc_load=1 -> HALT, pc unchanged, no further imem_rd_en.
- Wrap: pc=8'hFF, pc_en=1 -> the next imem_addr is 8'h00. Restart: start in HALT -> FETCH from START_ADDR, done drops after 1 cycle.
- SINGLE_STEP_EN: hold step=0 -> instr_valid does not reassert. Pulse step for 1 cycle -> exactly one further instruction executes.
